atm_bank_responder: RTL and testbench



---
 rtl/atm_pkg.sv | 23 ++
 rtl/atm_bank_responder.sv | 131 +++++++++++++
 tb/tb_atm_bank_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared types for the ATM bank responder: request kinds, result codes, FSM states.
package atm_pkg;
   localparam int CODE_W = 3;

   typedef enum logic {
      PIN_CHECK = 1'b0,
      WITHDRAW  = 1'b1
   } req_type_e;

   typedef enum logic [CODE_W-1:0] {
      OK      = 3'd0,
      BAD_PIN = 3'd1,
      LOCKED  = 3'd2,
      NSF     = 3'd3,
      NO_AUTH = 3'd4,
      BAD_REQ = 3'd5
   } resp_code_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } bank_state_e;
endpackage

// File: rtl/atm_bank_responder.sv
// Single-account responder: PIN verify and withdraw with fixed LAT-cycle latency,
// session authorisation, and lockout after MAX_TRIES consecutive bad PINs.
module atm_bank_responder
   import atm_pkg::*;
#(
   parameter int                 PIN_W      = 16,
   parameter int                 BAL_W      = 16,
   parameter logic [PIN_W-1:0]   STORED_PIN = 16'h1234,
   parameter int                 INIT_BAL   = 1000,
   parameter int                 MAX_TRIES  = 3,
   parameter int                 LAT        = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              session_start,
   input  logic              session_end,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_type,
   input  logic [PIN_W-1:0]  req_pin,
   input  logic [BAL_W-1:0]  req_amount,
   output logic              resp_valid,
   output logic [CODE_W-1:0] resp_code,
   output logic [BAL_W-1:0]  balance,
   output logic              authed,
   output logic              locked
);
   localparam int CNT_W  = 4;
   localparam int FAIL_W = 3;

   bank_state_e      state;
   logic [CNT_W-1:0] cnt;
   req_type_e        cap_type;
   logic [PIN_W-1:0] cap_pin;
   logic [BAL_W-1:0] cap_amt;
   logic [FAIL_W-1:0] fail_cnt;

   logic       sess_clr;
   logic       auth_eff;
   logic       pin_match;
   logic [FAIL_W-1:0] fail_next;
   resp_code_e eval_code;

   assign req_ready = (state == IDLE);
   assign sess_clr  = session_start | session_end;
   // A session edge in the evaluation cycle must already count as de-authorised.
   assign auth_eff  = authed & ~sess_clr;
   assign pin_match = (cap_pin == STORED_PIN);
   assign fail_next = fail_cnt + 1'b1;

   always_comb begin
      eval_code = OK;
      if (locked) begin
         eval_code = LOCKED;
      end else if (cap_type == PIN_CHECK) begin
         eval_code = pin_match ? OK : BAD_PIN;
      end else if (!auth_eff) begin
         eval_code = NO_AUTH;
      end else if (cap_amt == '0) begin
         eval_code = BAD_REQ;
      end else if (cap_amt > balance) begin
         eval_code = NSF;
      end else begin
         eval_code = OK;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         cap_type   <= PIN_CHECK;
         cap_pin    <= '0;
         cap_amt    <= '0;
         fail_cnt   <= '0;
         balance    <= BAL_W'(INIT_BAL);
         authed     <= 1'b0;
         locked     <= 1'b0;
         resp_valid <= 1'b0;
         resp_code  <= OK;
      end else begin
         resp_valid <= 1'b0;
         if (sess_clr) begin
            authed <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_type <= req_type_e'(req_type);
                  cap_pin  <= req_pin;
                  cap_amt  <= req_amount;
                  cnt      <= CNT_W'(LAT - 1);
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  resp_valid <= 1'b1;
                  resp_code  <= eval_code;
                  state      <= IDLE;
                  if (!locked) begin
                     if (cap_type == PIN_CHECK) begin
                        if (pin_match) begin
                           fail_cnt <= '0;
                           if (!sess_clr) begin
                              authed <= 1'b1;
                           end
                        end else begin
                           if (fail_cnt < FAIL_W'(MAX_TRIES)) begin
                              fail_cnt <= fail_next;
                           end
                           if (fail_next >= FAIL_W'(MAX_TRIES)) begin
                              locked <= 1'b1;
                              authed <= 1'b0;
                           end
                        end
                     end else if (eval_code == OK) begin
                        // amount <= balance here, so the subtraction cannot wrap.
                        balance <= balance - cap_amt;
                        authed  <= 1'b0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_atm_bank_responder.sv
// Scoreboard bench: the driver pushes hand-computed expectations, a monitor checks each response.
module tb_atm_bank_responder;
   localparam int LAT = 2;

   logic        clk = 0;
   logic        rst = 1;
   logic        session_start = 0;
   logic        session_end = 0;
   logic        req_valid = 0;
   logic        req_ready;
   logic        req_type = 0;
   logic [15:0] req_pin = 0;
   logic [15:0] req_amount = 0;
   logic        resp_valid;
   logic [2:0]  resp_code;
   logic [15:0] balance;
   logic        authed;
   logic        locked;

   atm_bank_responder dut (
      .clk(clk), .rst(rst), .session_start(session_start), .session_end(session_end),
      .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
      .req_pin(req_pin), .req_amount(req_amount), .resp_valid(resp_valid),
      .resp_code(resp_code), .balance(balance), .authed(authed), .locked(locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  code;
      logic [15:0] bal;
      bit          au;
      bit          lk;
      int          due;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every response strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (resp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_resp", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("resp_code", int'(resp_code), int'(e.code));
            chk("resp_latency", cyc, e.due);
            chk("resp_balance", int'(balance), int'(e.bal));
            chk("resp_authed", int'(authed), int'(e.au));
            chk("resp_locked", int'(locked), int'(e.lk));
         end
      end
   end

   // Returns one negedge after the accepting edge, with req_valid dropped.
   task automatic send(input bit t, input logic [15:0] pin, input logic [15:0] amt,
                       input logic [2:0] code, input logic [15:0] bal, input bit au, input bit lk);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      req_valid = 1; req_type = t; req_pin = pin; req_amount = amt;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 1, 0);
         req_valid = 0;
      end else begin
         last_acc = cyc + 1;
         e.code = code; e.bal = bal; e.au = au; e.lk = lk; e.due = last_acc + LAT;
         q.push_back(e);
         @(negedge clk);
         req_valid = 0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", int'(q.size()), 0);
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic pulse_end();
      session_end = 1;
      @(negedge clk);
      session_end = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
   endtask

   localparam bit PC = 1'b0;
   localparam bit WD = 1'b1;

   initial begin
      int acc1;
      do_reset();
      chk("rst_balance", int'(balance), 1000);
      chk("rst_locked", int'(locked), 0);
      chk("rst_authed", int'(authed), 0);
      chk("rst_ready", int'(req_ready), 1);
      chk("rst_resp_valid", int'(resp_valid), 0);

      // 1-3: authorisation, withdrawals, NSF, exact balance, zero amount
      send(PC, 16'h1234, 0,   3'd0, 1000, 1, 0);
      send(WD, 0,      300,   3'd0, 700,  0, 0);
      send(WD, 0,      100,   3'd4, 700,  0, 0);
      send(PC, 16'h1234, 0,   3'd0, 700,  1, 0);
      send(WD, 0,      701,   3'd3, 700,  1, 0);
      send(WD, 0,      700,   3'd0, 0,    0, 0);
      send(PC, 16'h1234, 0,   3'd0, 0,    1, 0);
      send(WD, 0,      0,     3'd5, 0,    1, 0);
      drain();

      // 4: lockout after three bad PINs
      send(PC, 16'h0000, 0,   3'd1, 0,    1, 0);
      send(PC, 16'h0000, 0,   3'd1, 0,    1, 0);
      send(PC, 16'h0000, 0,   3'd1, 0,    0, 1);
      send(PC, 16'h1234, 0,   3'd2, 0,    0, 1);
      send(WD, 0,      10,    3'd2, 0,    0, 1);
      drain();
      do_reset();
      chk("unlock_locked", int'(locked), 0);
      chk("unlock_balance", int'(balance), 1000);

      // 5: session_end mid-BUSY, in the evaluation cycle, and against a PIN OK
      send(PC, 16'h1234, 0,   3'd0, 1000, 1, 0);
      send(WD, 0,      50,    3'd4, 1000, 0, 0);
      pulse_end();
      drain();
      send(PC, 16'h1234, 0,   3'd0, 1000, 1, 0);
      send(WD, 0,      50,    3'd4, 1000, 0, 0);
      @(negedge clk);
      pulse_end();
      drain();
      send(PC, 16'h1234, 0,   3'd0, 1000, 0, 0);
      @(negedge clk);
      pulse_end();
      drain();
      send(PC, 16'h1234, 0,   3'd0, 1000, 1, 0);
      drain();
      session_start = 1;
      @(negedge clk);
      session_start = 0;
      chk("sess_start_clears", int'(authed), 0);

      // 6: reset aborts an in-flight withdraw; then back-to-back acceptance
      send(PC, 16'h1234, 0,   3'd0, 1000, 1, 0);
      drain();
      send(WD, 0,      200,   3'd0, 800,  0, 0);
      rst = 1;
      void'(q.pop_back());
      @(negedge clk);
      rst = 0;
      chk("abort_balance", int'(balance), 1000);
      chk("abort_authed", int'(authed), 0);
      chk("abort_ready", int'(req_ready), 1);
      repeat (LAT + 3) @(negedge clk);
      chk("abort_balance_later", int'(balance), 1000);

      send(PC, 16'h1234, 0,   3'd0, 1000, 1, 0);
      acc1 = last_acc;
      send(WD, 0,      400,   3'd0, 600,  0, 0);
      chk("b2b_accept_cycle", last_acc - acc1, LAT + 1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
